// File: rtl/fetch_seq.sv
// Y86-64 multi-cycle fetch sequencer.
// Reads one instruction a byte at a time and hands decoded fields to decode.
module fetch_seq #(
    parameter int unsigned IMEM_SIZE = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        mem_rd,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        inst_valid,
    output logic        imem_er,
    output logic        hlt_er
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_DONE
    } state_t;

    localparam logic [64:0] IMEM_LIM = 65'(IMEM_SIZE);

    // Instruction length in bytes, keyed by icode.
    function automatic logic [3:0] len_of(input logic [3:0] ic);
        logic [3:0] l;
        case (ic)
            4'h0, 4'h1, 4'h9:        l = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:  l = 4'd2;
            4'h3, 4'h4, 4'h5:        l = 4'd10;
            4'h7, 4'h8:              l = 4'd9;
            default:                 l = 4'd1;
        endcase
        return l;
    endfunction

    // Instructions whose byte 1 carries rA/rB.
    function automatic logic has_regs(input logic [3:0] ic);
        return (ic == 4'h2) || (ic == 4'h6) || (ic == 4'hA) ||
               (ic == 4'hB) || (ic == 4'h3) || (ic == 4'h4) ||
               (ic == 4'h5);
    endfunction

    state_t      state_q, state_d;
    logic [63:0] base_q, base_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic        inst_valid_q, inst_valid_d;
    logic        imem_er_q, imem_er_d;
    logic        hlt_er_q, hlt_er_d;

    logic [3:0]  cnt_inc;
    logic [64:0] next_addr;
    logic [3:0]  cur_icode;
    logic [3:0]  cur_len;
    logic        const_byte;

    // State and result registers; reset restores the cleared result values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            icode_q      <= '0;
            ifun_q       <= '0;
            ra_q         <= 4'hF;
            rb_q         <= 4'hF;
            valc_q       <= '0;
            valp_q       <= '0;
            inst_valid_q <= 1'b1;
            imem_er_q    <= 1'b0;
            hlt_er_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            icode_q      <= icode_d;
            ifun_q       <= ifun_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            valc_q       <= valc_d;
            valp_q       <= valp_d;
            inst_valid_q <= inst_valid_d;
            imem_er_q    <= imem_er_d;
            hlt_er_q     <= hlt_er_d;
        end
    end

    // Next-state and field capture; byte 0 length comes straight from rdata.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        icode_d      = icode_q;
        ifun_d       = ifun_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        valc_d       = valc_q;
        valp_d       = valp_q;
        inst_valid_d = inst_valid_q;
        imem_er_d    = imem_er_q;
        hlt_er_d     = hlt_er_q;

        cnt_inc   = cnt_q + 4'd1;
        next_addr = {1'b0, base_q} + {61'b0, cnt_inc};
        cur_icode = (cnt_q == 4'd0) ? mem_rdata[7:4] : icode_q;
        cur_len   = len_of(cur_icode);
        const_byte = (cnt_q != 4'd0) &&
                     ((((icode_q == 4'h3) || (icode_q == 4'h4) ||
                        (icode_q == 4'h5)) && (cnt_q >= 4'd2)) ||
                      (icode_q == 4'h7) || (icode_q == 4'h8));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d       = pc;
                    cnt_d        = '0;
                    icode_d      = '0;
                    ifun_d       = '0;
                    ra_d         = 4'hF;
                    rb_d         = 4'hF;
                    valc_d       = '0;
                    valp_d       = '0;
                    inst_valid_d = 1'b1;
                    imem_er_d    = 1'b0;
                    hlt_er_d     = 1'b0;
                    if ({1'b0, pc} < IMEM_LIM) begin
                        state_d = S_RD;
                    end else begin
                        state_d      = S_DONE;
                        imem_er_d    = 1'b1;
                        inst_valid_d = 1'b0;
                        valp_d       = pc;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (cnt_q == 4'd0) begin
                    icode_d = mem_rdata[7:4];
                    ifun_d  = mem_rdata[3:0];
                    if (mem_rdata[7:4] > 4'hB) begin
                        inst_valid_d = 1'b0;
                    end
                    if (mem_rdata[7:4] == 4'h0) begin
                        hlt_er_d = 1'b1;
                    end
                end
                if ((cnt_q == 4'd1) && has_regs(icode_q)) begin
                    ra_d = mem_rdata[7:4];
                    rb_d = mem_rdata[3:0];
                end
                if (const_byte) begin
                    valc_d = {valc_q[55:0], mem_rdata};
                end
                cnt_d = cnt_inc;
                if (cnt_inc == cur_len) begin
                    state_d = S_DONE;
                    valp_d  = base_q + {60'b0, cur_len};
                end else if (next_addr >= IMEM_LIM) begin
                    state_d      = S_DONE;
                    imem_er_d    = 1'b1;
                    inst_valid_d = 1'b0;
                    valp_d       = next_addr[63:0];
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_rd     = (state_q == S_RD);
    assign mem_addr   = (state_q == S_RD) ? (base_q + {60'b0, cnt_q}) : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign icode      = icode_q;
    assign ifun       = ifun_q;
    assign rA         = ra_q;
    assign rB         = rb_q;
    assign valC       = valc_q;
    assign valP       = valp_q;
    assign inst_valid = inst_valid_q;
    assign imem_er    = imem_er_q;
    assign hlt_er     = hlt_er_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq.
// Byte memory model answers reads one cycle later and logs read addresses.
module tb_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] pc;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        inst_valid;
    logic        imem_er;
    logic        hlt_er;

    logic [7:0]  mem [0:2047];
    logic [63:0] rd_log [$];

    int checks = 0;
    int errors = 0;
    int cyc;

    fetch_seq #(.IMEM_SIZE(2048)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pc         (pc),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .inst_valid (inst_valid),
        .imem_er    (imem_er),
        .hlt_er     (hlt_er)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = 8'h00;

    // Synchronous byte memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) begin
            rd_log.push_back(mem_addr);
            if (mem_addr < 64'd2048) begin
                mem_rdata <= mem[mem_addr[10:0]];
            end else begin
                mem_rdata <= 8'hXX;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and count cycles until done, bounded.
    task automatic do_fetch(input logic [63:0] p, output int n);
        rd_log.delete();
        @(negedge clk);
        pc    = p;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk("done_seen", {63'b0, done}, 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_rd"}, {63'b0, mem_rd}, 64'd0);
        chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
        chk({tag, "_done"}, {63'b0, done}, 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_icode"}, {60'b0, icode}, 64'd0);
        chk({tag, "_ifun"}, {60'b0, ifun}, 64'd0);
        chk({tag, "_rA"}, {60'b0, rA}, 64'hF);
        chk({tag, "_rB"}, {60'b0, rB}, 64'hF);
        chk({tag, "_valC"}, valC, 64'd0);
        chk({tag, "_valP"}, valP, 64'd0);
        chk({tag, "_inst_valid"}, {63'b0, inst_valid}, 64'd1);
        chk({tag, "_imem_er"}, {63'b0, imem_er}, 64'd0);
        chk({tag, "_hlt_er"}, {63'b0, hlt_er}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[11'h000] = 8'h10;
        mem[11'h020] = 8'h30; mem[11'h021] = 8'hF3;
        mem[11'h022] = 8'h01; mem[11'h023] = 8'h02;
        mem[11'h024] = 8'h03; mem[11'h025] = 8'h04;
        mem[11'h026] = 8'h05; mem[11'h027] = 8'h06;
        mem[11'h028] = 8'h07; mem[11'h029] = 8'h08;
        mem[11'h100] = 8'h80; mem[11'h108] = 8'h40;
        mem[11'h200] = 8'h00;
        mem[11'h210] = 8'hC0;
        mem[11'h300] = 8'h61; mem[11'h301] = 8'h12;
        mem[11'h400] = 8'h50; mem[11'h401] = 8'h37;
        mem[11'h402] = 8'h11; mem[11'h403] = 8'h22;
        mem[11'h404] = 8'h33; mem[11'h405] = 8'h44;
        mem[11'h7FF] = 8'h60;

        rst_n = 1'b0;
        start = 1'b0;
        pc    = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // nop
        do_fetch(64'h0, cyc);
        chk("nop_cyc", 64'(cyc), 64'd3);
        chk("nop_reads", 64'(rd_log.size()), 64'd1);
        if (rd_log.size() > 0) chk("nop_addr", rd_log[0], 64'h0);
        chk("nop_icode", {60'b0, icode}, 64'h1);
        chk("nop_ifun", {60'b0, ifun}, 64'h0);
        chk("nop_rA", {60'b0, rA}, 64'hF);
        chk("nop_rB", {60'b0, rB}, 64'hF);
        chk("nop_valC", valC, 64'h0);
        chk("nop_valP", valP, 64'h1);
        chk("nop_iv", {63'b0, inst_valid}, 64'd1);
        chk("nop_hlt", {63'b0, hlt_er}, 64'd0);

        // start held during done must not be accepted
        pc    = 64'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", {63'b0, busy}, 64'd0);
        chk("done_start_valP", valP, 64'h1);

        // irmovq
        do_fetch(64'h20, cyc);
        chk("irm_cyc", 64'(cyc), 64'd21);
        chk("irm_reads", 64'(rd_log.size()), 64'd10);
        for (int i = 0; i < rd_log.size(); i++)
            chk($sformatf("irm_addr%0d", i), rd_log[i], 64'h20 + 64'(i));
        chk("irm_icode", {60'b0, icode}, 64'h3);
        chk("irm_rA", {60'b0, rA}, 64'hF);
        chk("irm_rB", {60'b0, rB}, 64'h3);
        chk("irm_valC", valC, 64'h0102030405060708);
        chk("irm_valP", valP, 64'h2A);

        // call
        do_fetch(64'h100, cyc);
        chk("call_cyc", 64'(cyc), 64'd19);
        chk("call_icode", {60'b0, icode}, 64'h8);
        chk("call_valC", valC, 64'h40);
        chk("call_valP", valP, 64'h109);
        chk("call_rA", {60'b0, rA}, 64'hF);
        chk("call_rB", {60'b0, rB}, 64'hF);

        // halt
        do_fetch(64'h200, cyc);
        chk("hlt_cyc", 64'(cyc), 64'd3);
        chk("hlt_er", {63'b0, hlt_er}, 64'd1);
        chk("hlt_valP", valP, 64'h201);
        chk("hlt_iv", {63'b0, inst_valid}, 64'd1);

        // illegal icode
        do_fetch(64'h210, cyc);
        chk("ill_icode", {60'b0, icode}, 64'hC);
        chk("ill_iv", {63'b0, inst_valid}, 64'd0);
        chk("ill_valP", valP, 64'h211);
        chk("ill_hlt", {63'b0, hlt_er}, 64'd0);

        // OPq 2-byte
        do_fetch(64'h300, cyc);
        chk("op_cyc", 64'(cyc), 64'd5);
        chk("op_ifun", {60'b0, ifun}, 64'h1);
        chk("op_rA", {60'b0, rA}, 64'h1);
        chk("op_rB", {60'b0, rB}, 64'h2);
        chk("op_valP", valP, 64'h302);
        chk("op_valC", valC, 64'h0);

        // runs off the end of memory after byte 0
        do_fetch(64'd2047, cyc);
        chk("end_cyc", 64'(cyc), 64'd3);
        chk("end_reads", 64'(rd_log.size()), 64'd1);
        chk("end_icode", {60'b0, icode}, 64'h6);
        chk("end_imem_er", {63'b0, imem_er}, 64'd1);
        chk("end_iv", {63'b0, inst_valid}, 64'd0);
        chk("end_valP", valP, 64'd2048);

        // out-of-range pc
        do_fetch(64'd4096, cyc);
        chk("oor_cyc", 64'(cyc), 64'd1);
        chk("oor_reads", 64'(rd_log.size()), 64'd0);
        chk("oor_imem_er", {63'b0, imem_er}, 64'd1);
        chk("oor_iv", {63'b0, inst_valid}, 64'd0);
        chk("oor_valP", valP, 64'd4096);
        chk("oor_icode", {60'b0, icode}, 64'h0);

        // mrmovq interrupted by reset during byte 4
        rd_log.delete();
        @(negedge clk);
        pc    = 64'h400;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        pc    = 64'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrm_rd4", {63'b0, mem_rd}, 64'd1);
        chk("mrm_addr4", mem_addr, 64'h404);
        chk("mrm_rA", {60'b0, rA}, 64'h3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        chk("mrm_reads", 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < rd_log.size(); i++)
            chk($sformatf("mrm_addr%0d", i), rd_log[i], 64'h400 + 64'(i));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fetch after reset release
        do_fetch(64'h300, cyc);
        chk("post_cyc", 64'(cyc), 64'd5);
        chk("post_rA", {60'b0, rA}, 64'h1);
        chk("post_rB", {60'b0, rB}, 64'h2);
        chk("post_valP", valP, 64'h302);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Multi-cycle instruction fetch sequencer for the Y86-64 core.
- Reads one instruction from a single-port, byte-wide instruction memory, one byte per access. Uses the icode in the first byte to decide how many more bytes to read.
- Presents the decoded fields (icode, ifun, rA, rB, valC, valP) plus status flags to the decode stage through a start/done handshake.
- Sits between the PC register and the instruction memory; it is the only master of the imem read port.

Parameters:
- IMEM_SIZE, 2048, instruction memory size in bytes; valid addresses are 0..IMEM_SIZE-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  fetch request; sampled only in IDLE.
- pc  in  64  fetch address; latched on an accepted start.
- mem_rd  out  1  imem read strobe.
- mem_addr  out  64  imem byte address.
- mem_rdata  in  8  read data; valid the cycle after mem_rd.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; all result outputs are valid from this cycle on.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register specifier A.
- rB  out  4  register specifier B.
- valC  out  64  constant word.
- valP  out  64  address of the next sequential instruction.
- inst_valid  out  1  1 if the icode is legal.
- imem_er  out  1  address error.
- hlt_er  out  1  halt encountered.

Behaviour:
- Reset (async on rst_n=0, effective immediately, also when asserted mid-fetch):
  - state returns to IDLE; mem_rd=0, busy=0, done=0.
  - mem_addr, valC and valP are cleared to 0; icode=ifun=0; rA=rB=4'hF.
  - inst_valid=1; imem_er=0; hlt_er=0.
- States: IDLE, RD, CAP, DONE.
- IDLE:
  - start=1 latches pc into base, clears the byte count cnt, and clears all result outputs to their reset values.
  - Goes to RD if pc < IMEM_SIZE.
  - Otherwise goes to DONE with imem_er=1, inst_valid=0, valP=pc; no memory access is made.
- RD:
  - mem_rd=1 and mem_addr=base+cnt for exactly one cycle, then go to CAP.
  - mem_rd=0 in every other state.
- CAP: capture mem_rdata.
  - Byte 0: icode=rdata[7:4], ifun=rdata[3:0]. Length len comes from icode:
    - 0, 1, 9 → 1
    - 2, 6, A, B → 2
    - 3, 4, 5 → 10
    - 7, 8 → 9
    - any other icode → 1, with inst_valid=0.
  - icode 0 additionally sets hlt_er=1.
  - Byte 1 of a 2- or 10-byte instruction: rA=rdata[7:4], rB=rdata[3:0].
  - Constant bytes (bytes 2..9 for icode 3/4/5, bytes 1..8 for icode 7/8) shift into valC MSB-first: valC={valC[55:0],rdata}. The first constant byte fetched ends up in valC[63:56].
  - Then cnt=cnt+1. If cnt equals len, go to DONE with valP=base+len.
  - Otherwise, if base+cnt >= IMEM_SIZE, go to DONE with imem_er=1, inst_valid=0, valP=base+cnt. This compare uses 65-bit arithmetic, so no wrap-around occurs.
  - Otherwise return to RD.
- DONE: done=1 for one cycle, then IDLE.
- Result outputs hold their values until the next accepted start or reset.
- Fields not defined by the instruction stay at their cleared values: rA=rB=F, valC=0.
- Latency: an accepted start at edge 0 gives done high in cycle 2·len+1. Examples: 3 cycles for 1 byte, 19 for 9 bytes, 21 for 10 bytes. An immediate address error gives done in cycle 1.
- start while busy=1 is ignored and not queued.
- start asserted in the same cycle as done is ignored; it is accepted only in IDLE.
- Back-to-back fetches: minimum gap is one IDLE cycle after DONE.
- mem_rdata is sampled only in CAP; its value in other cycles is don't-care.

Test Plan:
- nop (byte 10) at pc=0, start pulse → one read at addr 0. done at cycle 3 with icode=1, ifun=0, rA=rB=F, valC=0, valP=1, inst_valid=1, hlt_er=0.
- irmovq at pc=0x20, bytes 30 F3 01 02 03 04 05 06 07 08 → reads of addr 0x20..0x29 in order. done at cycle 21 with rA=F, rB=3, valC=0x0102030405060708, valP=0x2A.
- call at pc=0x100, bytes 80 00..00 40 → done at cycle 19 with icode=8, valC=0x40, valP=0x109, rA=rB=F.
- halt (00) → hlt_er=1, valP=pc+1. Byte C0 → inst_valid=0, valP=pc+1.
- pc=2047 with byte 6 0x60 → after byte 0, stops with imem_er=1, inst_valid=0, valP=2048; exactly one read. pc=4096 → done at cycle 1, imem_er=1, no mem_rd.
- rst_n pulled low during byte 4 of an mrmovq → outputs return to reset values within the same cycle and mem_rd=0. A start asserted while busy (before the reset) causes no extra fetch. After release, a new start fetches correctly.
